// File: rtl/lc3b_types.sv
// Shared lc3b cache constants, width-parametrised typedefs and the cache
// controller state enum.
package lc3b_types;

    localparam int unsigned CACHE_WAYS  = 4;
    localparam int unsigned CACHE_TAG_W = 9;
    localparam int unsigned CACHE_SET_W = 3;
    localparam int unsigned CACHE_OFF_W = 4;
    localparam int unsigned CACHE_WAY_W = $clog2(CACHE_WAYS);

    typedef logic [CACHE_TAG_W-1:0] lc3b_cache_tag;
    typedef logic [CACHE_WAY_W-1:0] lc3b_cache_way;

    typedef enum logic [1:0] {
        CC_IDLE,
        CC_WRITEBACK,
        CC_FILL
    } cache_state_e;

endpackage

// File: rtl/way_prio_enc.sv
// Lowest-set-bit priority encoder over a per-way vector, plus an any-bit flag.
module way_prio_enc #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  vec,
    output logic [WAY_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (vec[i] && !any) begin
                idx = WAY_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: hit handling, victim write-back and
// line fill. Optional CACHE_PERF_CNT_EN adds saturating hit/miss/write-back counters.
module cache_control_nway
    import lc3b_types::*;
#(
    parameter int unsigned  WAYS  = CACHE_WAYS,
    localparam int unsigned WAY_W = $clog2(WAYS),
    parameter int unsigned  TAG_W = CACHE_TAG_W,
    parameter int unsigned  SET_W = CACHE_SET_W,
    parameter int unsigned  OFF_W = CACHE_OFF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      mem_address,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAY_W-1:0] victim_way,
    output logic [WAY_W-1:0] way_sel,
    input  logic [TAG_W-1:0] sel_tag,
    output logic [WAYS-1:0]  ld_data,
    output logic [WAYS-1:0]  ld_tag,
    output logic [WAYS-1:0]  ld_dirty,
    output logic             dirty_in,
    output logic             fill_sel,
    output logic             ld_lru,
    output logic [WAY_W-1:0] mru_way,
    output logic [15:0]      pmem_address,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt,
    output logic [15:0]      wb_cnt
`endif
);

    if (TAG_W + SET_W + OFF_W != 16) begin : g_bad_addr_split
        $error("cache_control_nway: TAG_W+SET_W+OFF_W must equal 16");
    end
    if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("cache_control_nway: WAYS must be a power of 2 and >= 2");
    end

    localparam logic [WAYS-1:0] WAY_ONE = WAYS'(1);

    cache_state_e     state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [WAY_W-1:0] hit_idx;
    logic             hit;
    logic             req;
    logic             count_hit, count_miss, count_wb;
    logic [WAYS-1:0]  hit_oh, victim_oh;

    way_prio_enc #(
        .WAYS (WAYS),
        .WAY_W(WAY_W)
    ) u_hit_enc (
        .vec(hit_vec),
        .idx(hit_idx),
        .any(hit)
    );

    assign req       = mem_read | mem_write;
    assign hit_oh    = WAY_ONE << hit_idx;
    assign victim_oh = WAY_ONE << victim_q;

    // rst_n gates the combinational outputs so everything except the
    // address is quiet while reset is held, regardless of CPU inputs.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        way_sel      = victim_q;
        ld_data      = '0;
        ld_tag       = '0;
        ld_dirty     = '0;
        dirty_in     = 1'b0;
        fill_sel     = 1'b0;
        ld_lru       = 1'b0;
        mru_way      = '0;
        pmem_address = mem_address;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        count_hit    = 1'b0;
        count_miss   = 1'b0;
        count_wb     = 1'b0;
        if (rst_n) begin
            case (state_q)
                CC_IDLE: begin
                    if (req && hit) begin
                        mem_resp  = 1'b1;
                        ld_lru    = 1'b1;
                        mru_way   = hit_idx;
                        way_sel   = hit_idx;
                        count_hit = 1'b1;
                        if (mem_write) begin
                            ld_data  = hit_oh;
                            ld_dirty = hit_oh;
                            dirty_in = 1'b1;
                        end
                    end else if (req) begin
                        victim_d   = victim_way;
                        count_miss = 1'b1;
                        state_d    = dirty_vec[victim_way] ? CC_WRITEBACK : CC_FILL;
                    end
                end
                CC_WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {sel_tag, mem_address[OFF_W+SET_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (pmem_resp) begin
                        ld_dirty = victim_oh;
                        count_wb = 1'b1;
                        state_d  = CC_FILL;
                    end
                end
                CC_FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {mem_address[15:OFF_W], {OFF_W{1'b0}}};
                    if (pmem_resp) begin
                        ld_data  = victim_oh;
                        ld_tag   = victim_oh;
                        ld_dirty = victim_oh;
                        fill_sel = 1'b1;
                        state_d  = CC_IDLE;
                    end
                end
                default: state_d = CC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CC_IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic [15:0] wb_cnt_q, wb_cnt_d;
    logic        fill_done_q, fill_done_d;

    // fill_done marks the first IDLE cycle after a fill, whose hit is the
    // miss completing rather than a first-try hit.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        wb_cnt_d    = wb_cnt_q;
        fill_done_d = (state_q == CC_FILL) && (state_d == CC_IDLE);
        if (count_hit && !fill_done_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
        if (count_miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
        if (count_wb && wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
            fill_done_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Self-checking bench for cache_control_nway: directed scenarios followed by
// random transactions checked against a transaction-level model.
module tb_cache_control_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_address;
    logic        mem_read, mem_write, mem_resp;
    logic [3:0]  hit_vec, dirty_vec;
    logic [1:0]  victim_way, way_sel, mru_way;
    logic [8:0]  sel_tag;
    logic [3:0]  ld_data, ld_tag, ld_dirty;
    logic        dirty_in, fill_sel, ld_lru;
    logic [15:0] pmem_address;
    logic        pmem_read, pmem_write, pmem_resp;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int m_hits = 0, m_misses = 0, m_wbs = 0;
    logic [1:0] last_vic = 2'd0;

    always #5 clk = ~clk;

    cache_control_nway dut (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit_vec(hit_vec), .dirty_vec(dirty_vec),
        .victim_way(victim_way), .way_sel(way_sel), .sel_tag(sel_tag),
        .ld_data(ld_data), .ld_tag(ld_tag), .ld_dirty(ld_dirty),
        .dirty_in(dirty_in), .fill_sel(fill_sel), .ld_lru(ld_lru),
        .mru_way(mru_way), .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index of the lowest set bit: isolate it with v & -v, then take log2.
    function automatic int low_set(input logic [3:0] v);
        logic [3:0] iso;
        iso = v & (~v + 4'd1);
        return $clog2(iso);
    endfunction

    task automatic check_counts(input string tag);
`ifdef CACHE_PERF_CNT_EN
        chk({tag, "_hit_cnt"}, hit_cnt, m_hits);
        chk({tag, "_miss_cnt"}, miss_cnt, m_misses);
        chk({tag, "_wb_cnt"}, wb_cnt, m_wbs);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One idle cycle: no request, random stray pmem_resp that must be ignored.
    task automatic quiet(input string tag);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit_vec   = 4'b0;
        pmem_resp = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({tag, "_resp"}, mem_resp, 0);
        chk({tag, "_strobes"}, {ld_data, ld_tag, ld_dirty, ld_lru, dirty_in, fill_sel}, 0);
        chk({tag, "_pmem_rw"}, {pmem_read, pmem_write}, 0);
        chk({tag, "_pmem_addr"}, pmem_address, mem_address);
        chk({tag, "_way_sel"}, way_sel, last_vic);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
    endtask

    task automatic txn(input logic [15:0] addr, input bit rd, input bit wr,
                       input logic [3:0] hv, input logic [3:0] dv, input logic [1:0] vic,
                       input logic [8:0] stag, input int wb_lat, input int fill_lat,
                       input bit drop);
        logic [3:0]  voh;
        logic [15:0] wb_addr, fill_addr;
        int          hi;
        mem_address = addr; mem_read = rd; mem_write = wr;
        hit_vec = hv; dirty_vec = dv; victim_way = vic; sel_tag = stag; pmem_resp = 1'b0;
        @(negedge clk);
        if (hv != 4'b0) begin
            hi = low_set(hv);
            chk("hit_resp", mem_resp, 1);
            chk("hit_ld_lru", ld_lru, 1);
            chk("hit_mru_way", mru_way, hi);
            chk("hit_way_sel", way_sel, hi);
            chk("hit_ld_data", ld_data, wr ? (1 << hi) : 0);
            chk("hit_ld_dirty", ld_dirty, wr ? (1 << hi) : 0);
            chk("hit_dirty_in", dirty_in, wr);
            chk("hit_fill_sel_tag", {fill_sel, ld_tag}, 0);
            chk("hit_pmem_rw", {pmem_read, pmem_write}, 0);
            m_hits++;
            @(posedge clk); #1;
        end else begin
            chk("miss_resp", mem_resp, 0);
            chk("miss_strobes", {ld_data, ld_tag, ld_dirty, ld_lru}, 0);
            chk("miss_way_sel", way_sel, last_vic);
            chk("miss_pmem_rw", {pmem_read, pmem_write}, 0);
            m_misses++;
            last_vic = vic;
            voh = 4'(1 << vic);
            @(posedge clk); #1;
            victim_way = ~vic;
            if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
            if (dv[vic]) begin
                m_wbs++;
                wb_addr = 16'(int'(stag) * 128 + ((int'(addr) / 16) % 8) * 16);
                for (int k = 0; k < wb_lat; k++) begin
                    pmem_resp = (k == wb_lat - 1);
                    @(negedge clk);
                    chk("wb_pmem_rw", {pmem_read, pmem_write}, 2'b01);
                    chk("wb_pmem_addr", pmem_address, wb_addr);
                    chk("wb_way_sel", way_sel, vic);
                    chk("wb_ld_dirty", ld_dirty, pmem_resp ? voh : 0);
                    chk("wb_other", {mem_resp, ld_data, ld_tag, dirty_in}, 0);
                    @(posedge clk); #1;
                end
            end
            fill_addr = addr - (addr % 16);
            for (int k = 0; k < fill_lat; k++) begin
                pmem_resp = (k == fill_lat - 1);
                @(negedge clk);
                chk("fill_pmem_rw", {pmem_read, pmem_write}, 2'b10);
                chk("fill_pmem_addr", pmem_address, fill_addr);
                chk("fill_ld_data", ld_data, pmem_resp ? voh : 0);
                chk("fill_ld_tag", ld_tag, pmem_resp ? voh : 0);
                chk("fill_ld_dirty", ld_dirty, pmem_resp ? voh : 0);
                chk("fill_sel", fill_sel, pmem_resp);
                chk("fill_other", {mem_resp, dirty_in, ld_lru}, 0);
                @(posedge clk); #1;
            end
            pmem_resp = 1'b0;
            hit_vec   = voh;
            @(negedge clk);
            if (drop) begin
                chk("drop_resp", {mem_resp, ld_lru, ld_data}, 0);
            end else begin
                chk("done_resp", mem_resp, 1);
                chk("done_mru_way", mru_way, vic);
                chk("done_ld_data", ld_data, wr ? voh : 0);
            end
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; hit_vec = 4'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_address = 16'hBEEF; mem_read = 1'b1; mem_write = 1'b0;
        hit_vec = 4'b0100; dirty_vec = 4'b0; victim_way = 2'd3; sel_tag = 9'h0; pmem_resp = 1'b1;
        #2;
        chk("rst_resp", mem_resp, 0);
        chk("rst_strobes", {ld_data, ld_tag, ld_dirty, ld_lru, dirty_in, fill_sel}, 0);
        chk("rst_sel", {way_sel, mru_way}, 0);
        chk("rst_pmem_rw", {pmem_read, pmem_write}, 0);
        chk("rst_pmem_addr", pmem_address, 16'hBEEF);
        check_counts("rst");
        #10 rst_n = 1'b1;
        mem_read = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;
        quiet("idle0");

        txn(16'h0100, 1, 0, 4'b0100, 4'b0000, 2'd0, 9'h0, 1, 1, 0);
        txn(16'h0200, 0, 1, 4'b0001, 4'b0000, 2'd0, 9'h0, 1, 1, 0);
        txn(16'h0300, 1, 0, 4'b0110, 4'b1111, 2'd2, 9'h0, 1, 1, 0);
        txn(16'h1234, 1, 0, 4'b0000, 4'b0000, 2'd3, 9'h0, 1, 5, 0);
        quiet("idle1");
        txn(16'h4537, 1, 1, 4'b0000, 4'b0010, 2'd1, 9'h1AB, 3, 2, 0);
        quiet("idle2");
        check_counts("plan");

        // Reset asserted mid-fill: pmem_read must drop without waiting for a clock.
        mem_address = 16'h7777; mem_read = 1'b1; hit_vec = 4'b0; dirty_vec = 4'b0; victim_way = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("prerst_pmem_read", pmem_read, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pmem_rw", {pmem_read, pmem_write}, 0);
        chk("midrst_strobes", {mem_resp, ld_data, ld_tag, ld_dirty, ld_lru}, 0);
        chk("midrst_pmem_addr", pmem_address, 16'h7777);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_vic = 2'd0; m_hits = 0; m_misses = 0; m_wbs = 0;
        quiet("postrst");
        check_counts("postrst");

        txn(16'h2468, 1, 0, 4'b0000, 4'b1111, 2'd2, 9'h155, 2, 2, 1);
        quiet("postdrop");

        for (int t = 0; t < 40; t++) begin
            logic [3:0] hv;
            bit wr, rd;
            hv = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(16'($urandom), rd, wr, hv, 4'($urandom), 2'($urandom), 9'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 7) == 0);
            quiet("rnd_idle");
        end
        check_counts("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
Parametrised N-way set-associative cache controller for the lc3b memory hierarchy; generalises the 2-way controller to WAYS ways.
- Latches the replacement victim at miss detection, so LRU updates elsewhere cannot corrupt an in-flight miss.
- Issues write-back and line-fill bursts to physical memory.
- Drives per-way one-hot load strobes into the cache datapath (tag/data/dirty arrays, LRU logic).
- Sits between the CPU memory port and physical memory / arbiter; used for both I-cache and D-cache instances.

Parameters:
WAYS, 4, associativity; power of 2, >=2
WAY_W, $clog2(WAYS), way index width (derived, not overridden)
TAG_W, 9, tag bits
SET_W, 3, set index bits
OFF_W, 4, line offset bits; TAG_W+SET_W+OFF_W must equal 16 (elaboration assertion)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_address  in  16  CPU address {tag,set,offset}
mem_read  in  1  CPU read request
mem_write  in  1  CPU write request
mem_resp  out  1  request complete this cycle
hit_vec  in  WAYS  per-way tag match & valid for indexed set
dirty_vec  in  WAYS  per-way dirty bits of indexed set
victim_way  in  WAY_W  replacement choice from LRU array for indexed set
way_sel  out  WAY_W  datapath way mux select (tag/data readout)
sel_tag  in  TAG_W  stored tag of way way_sel
ld_data  out  WAYS  one-hot data array load
ld_tag  out  WAYS  one-hot tag/valid load
ld_dirty  out  WAYS  one-hot dirty load
dirty_in  out  1  value written on ld_dirty
fill_sel  out  1  1=line from pmem, 0=CPU write merge
ld_lru  out  1  update LRU for indexed set
mru_way  out  WAY_W  way to mark most-recently-used
pmem_address  out  16  physical line address
pmem_read  out  1  line read request
pmem_write  out  1  line write-back request
pmem_resp  in  1  physical memory done

Behaviour:
- States: IDLE, WRITEBACK, FILL. Reset (async, rst_n=0): state=IDLE, victim_q=0. Every output 0 except pmem_address=mem_address. pmem_read/pmem_write drop immediately, even mid-burst.
- Outputs are combinational from state+inputs. Defaults: all strobes 0, pmem_address=mem_address, way_sel=victim_q.
- req = mem_read|mem_write; both set at once is treated as a write. hit = |hit_vec; hit_idx = lowest set bit of hit_vec (multi-hot resolves to lowest).
- IDLE, req & hit:
  - mem_resp=1 in the same cycle; ld_lru=1; mru_way=hit_idx; way_sel=hit_idx.
  - If write: ld_data[hit_idx]=1, fill_sel=0, ld_dirty[hit_idx]=1, dirty_in=1.
  - Stay in IDLE.
- IDLE, req & ~hit: victim_q<=victim_way. Next state is WRITEBACK if dirty_vec[victim_way], else FILL. No mem_resp.
- IDLE, no req: no strobes.
- WRITEBACK:
  - way_sel=victim_q; pmem_write=1; pmem_address={sel_tag, mem_address[OFF_W+SET_W-1:OFF_W], OFF_W'b0}.
  - On pmem_resp: ld_dirty[victim_q]=1, dirty_in=0, go to FILL.
- FILL:
  - pmem_read=1; pmem_address={mem_address[15:OFF_W], OFF_W'b0}.
  - On pmem_resp: ld_data, ld_tag and ld_dirty at victim_q, fill_sel=1, dirty_in=0, go to IDLE.
- Miss completes as a hit in IDLE the cycle after the FILL resp. Latency:
  - clean miss = 1 + fill cycles + 1;
  - dirty miss adds the write-back cycles.
- Request dropped mid-miss: the burst still completes and the line is installed; no mem_resp.
- pmem_resp is ignored in IDLE.
- CPU address and request must be held stable until mem_resp; violating this is undefined.

Optional Feature:
CACHE_PERF_CNT_EN:
- When defined, adds outputs hit_cnt, miss_cnt, wb_cnt (each 16 bits).
  - hit_cnt increments on each IDLE first-try hit.
  - miss_cnt increments on each IDLE miss detection.
  - wb_cnt increments on each WRITEBACK completion.
- Counters saturate at 16'hFFFF and reset to 0 on rst_n.
- The post-fill completion hit is not counted as a hit.
- When undefined, these ports and registers are absent.

Decomposition:
- lc3b_types gains cache constants (CACHE_WAYS, CACHE_TAG_W, CACHE_SET_W, CACHE_OFF_W), parametrised tag/way typedefs, and the state enum.
- One sub-module: way_prio_enc (WAYS-bit vector to lowest-set index plus any-bit flag); used for hit_idx.

Test Plan:
- Read hit: hit_vec=4'b0100, mem_read=1 -> same-cycle mem_resp=1, ld_lru=1, mru_way=2, ld_data=0.
- Write hit: hit_vec=4'b0001, mem_write=1 -> mem_resp=1, ld_data=4'b0001, ld_dirty=4'b0001, dirty_in=1, fill_sel=0.
- Clean miss: address 16'h1234, victim_way=3, dirty_vec=0, pmem_resp after 5 cycles -> FILL with pmem_address=16'h1230. On resp: ld_data/ld_tag=4'b1000, fill_sel=1. Next-cycle hit gives mem_resp.
- Dirty miss: victim_way=1, dirty_vec=4'b0010, sel_tag=9'h1AB, set=3 -> pmem_write with pmem_address=16'hD5B0. On resp: ld_dirty=4'b0010, dirty_in=0, then FILL. Also change victim_way mid-miss: fill still targets way 1.
- Reset mid-FILL: drop rst_n -> pmem_read=0 immediately; state IDLE after release; no strobes.
- Multi-hot hit_vec=4'b0110 -> mru_way=1. With CACHE_PERF_CNT_EN: 3 hits, 2 misses, 1 write-back give counts 3/2/1.
